// File: rtl/fuzz_top.sv
// Registered multi-function stress datapath: four operand buses in, one 336-bit result word out.
// Optional accumulator field enabled by defining FUZZ_TOP_ACC_EN.
module fuzz_top (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [25:0] wire0,
    input  logic signed [24:0] wire1,
    input  logic        [14:0] wire2,
    input  logic signed [5:0]  wire3,
    output logic [335:0]       y
);

    logic        [71:0] in_vec;
    logic signed [25:0] w1_sx;
    logic        [25:0] sum_d, diff_d, shl_d;
    logic signed [30:0] prod_d;
    logic        [24:0] mix_d;
    logic        [7:0]  flags_d;
    logic        [6:0]  pop_d;
    logic        [31:0] misr_d;
    logic        [47:0] acc_out;

    logic        [25:0] sum_q, diff_q, shl_q;
    logic        [30:0] prod_q;
    logic        [24:0] mix_q;
    logic        [7:0]  flags_q;
    logic        [6:0]  pop_q;
    logic        [71:0] hist1_q, hist2_q;
    logic        [31:0] misr_q;
    logic        [34:0] cnt_q;

    assign in_vec = {wire3, wire2, wire1, wire0};
    assign w1_sx  = {wire1[24], wire1};

    always_comb begin
        sum_d  = wire0 + w1_sx;
        diff_d = wire0 - w1_sx;
        // Both operands widened to the product width so the signed multiply keeps all 31 bits.
        prod_d = $signed({{6{wire1[24]}}, wire1}) * $signed({{25{wire3[5]}}, wire3});
        mix_d  = wire1 ^ {wire2, wire3, 4'b0000};
        shl_d  = wire0 << wire3[4:0];

        flags_d[0] = (wire0 == 26'd0);
        flags_d[1] = (wire0 < w1_sx);
        flags_d[2] = wire1[24];
        flags_d[3] = wire3[5];
        flags_d[4] = ^wire0;
        flags_d[5] = ^wire2;
        flags_d[6] = (wire2 == 15'd0);
        flags_d[7] = &wire3;

        pop_d = 7'd0;
        for (int i = 0; i < 72; i++) begin
            pop_d = pop_d + 7'(in_vec[i]);
        end

        misr_d = {misr_q[30:0], misr_q[31] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0]}
                 ^ {wire0, wire3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            diff_q  <= '0;
            prod_q  <= '0;
            mix_q   <= '0;
            flags_q <= '0;
            pop_q   <= '0;
            shl_q   <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
            misr_q  <= 32'hFFFF_FFFF;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            diff_q  <= diff_d;
            prod_q  <= prod_d;
            mix_q   <= mix_d;
            flags_q <= flags_d;
            pop_q   <= pop_d;
            shl_q   <= shl_d;
            hist1_q <= in_vec;
            hist2_q <= hist1_q;
            misr_q  <= misr_d;
            cnt_q   <= cnt_q + 35'd1;
        end
    end

`ifdef FUZZ_TOP_ACC_EN
    logic [47:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_q + {{22{wire0[25]}}, wire0};
        end
    end

    assign acc_out = acc_q;
`else
    assign acc_out = '0;
`endif

    assign y = {cnt_q, misr_q, hist2_q, shl_q, pop_q, acc_out, flags_q, mix_q, prod_q,
                diff_q, sum_q};

endmodule

// File: tb/tb_fuzz_top.sv
// Directed self-checking bench for fuzz_top with hand-computed expected values.
// Honours FUZZ_TOP_ACC_EN for the accumulator field expectations.
module tb_fuzz_top;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [25:0] wire0;
    logic signed [24:0] wire1;
    logic        [14:0] wire2;
    logic signed [5:0]  wire3;
    logic [335:0]       y;

    int n_checks = 0;
    int n_bad    = 0;

`ifdef FUZZ_TOP_ACC_EN
    localparam logic [47:0] AccAfter1 = 48'd100;
    localparam logic [47:0] AccAfter3 = 48'hFFFF_FFFF_FFFA;
`else
    localparam logic [47:0] AccAfter1 = 48'd0;
    localparam logic [47:0] AccAfter3 = 48'd0;
`endif

    localparam logic [71:0] V1 = 72'h01_2345_6789_ABCD_EF01;
    localparam logic [71:0] V2 = 72'hA5_5A3C_96F0_1234_5678;
    localparam logic [71:0] V3 = 72'hFE_DCBA_9876_5432_10FE;

    fuzz_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wire0 (wire0),
        .wire1 (wire1),
        .wire2 (wire2),
        .wire3 (wire3),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [71:0] v);
        {wire3, wire2, wire1, wire0} = v;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_misr"}, 72'(y[300:269]), 72'hFFFF_FFFF);
        check({tag, "_rest"}, 72'(|{y[335:301], y[268:0]}), 72'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        set_in(72'd0);
        #1 rst_n = 1'b0;
        #2 check_reset("rst");

        // Basic arithmetic and flags
        wire0 = 26'd100;
        wire1 = 25'h1FF_FFFF;
        wire2 = 15'd0;
        wire3 = 6'd0;
        #1 rst_n = 1'b1;
        step();
        check("sum",   72'(y[25:0]),    72'd99);
        check("diff",  72'(y[51:26]),   72'd101);
        check("prod",  72'(y[82:52]),   72'd0);
        check("mix",   72'(y[107:83]),  72'h1FF_FFFF);
        check("flags", 72'(y[115:108]), 72'h54);
        check("acc1",  72'(y[163:116]), 72'(AccAfter1));
        check("pop",   72'(y[170:164]), 72'd28);
        check("shl",   72'(y[196:171]), 72'd100);
        check("hist0", 72'(y[268:197]), 72'd0);
        check("misr",  72'(y[300:269]), 72'hFFFF_E6FE);
        check("cnt1",  72'(y[335:301]), 72'd1);

        // Signed product and shift
        wire0 = 26'd1;
        wire1 = 25'h1FF_FFFD;
        wire3 = 6'd5;
        step();
        check("prod_neg", 72'(y[82:52]),   72'h7FFF_FFF1);
        check("shl5",     72'(y[196:171]), 72'd32);

        wire3 = 6'h23;
        step();
        check("shl_msb_ign", 72'(y[196:171]), 72'd8);
        check("prod_negneg", 72'(y[82:52]),   72'd87);

        wire3 = 6'd25;
        step();
        check("shl25", 72'(y[196:171]), 72'h200_0000);
        wire3 = 6'd26;
        step();
        check("shl26", 72'(y[196:171]), 72'd0);

        // Most-negative operand wraparound
        wire0 = 26'h200_0000;
        wire1 = 25'h1FF_FFFF;
        wire2 = 15'd0;
        wire3 = 6'h3F;
        step();
        check("sum_min",   72'(y[25:0]),    72'h1FF_FFFF);
        check("diff_min",  72'(y[51:26]),   72'h200_0001);
        check("prod_one",  72'(y[82:52]),   72'd1);
        check("mix_min",   72'(y[107:83]),  72'h1FF_FC0F);
        check("flags_min", 72'(y[115:108]), 72'hDE);
        check("pop_min",   72'(y[170:164]), 72'd32);

        wire0 = 26'd0;
        wire1 = 25'd0;
        wire2 = 15'd7;
        wire3 = 6'd0;
        step();
        check("flags_zero", 72'(y[115:108]), 72'h21);
        check("pop_zero",   72'(y[170:164]), 72'd3);
        check("sum_zero",   72'(y[25:0]),    72'd0);

        // Mid-operation reset, then accumulator
        rst_n = 1'b0;
        #1 check_reset("rst_mid");
        wire0 = 26'h3FF_FFFE;
        wire1 = 25'd0;
        wire2 = 15'd0;
        wire3 = 6'd0;
        #1 rst_n = 1'b1;
        step();
        step();
        step();
        check("acc3", 72'(y[163:116]), 72'(AccAfter3));
        check("cnt3", 72'(y[335:301]), 72'd3);

        // Two-stage history
        set_in(V1);
        step();
        set_in(V2);
        step();
        set_in(V3);
        step();
        check("hist", 72'(y[268:197]), V2);
        check("cnt6", 72'(y[335:301]), 72'd6);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/fuzz_top.md
# fuzz_top

Registered multi-function datapath that samples four signed/unsigned operand buses every clock and presents a 336-bit packed result word. Fields are arithmetic, logic, flag, accumulator, signature and counter results. It is a self-checking stress block for synthesis/simulation equivalence flows. Downstream logic or a bench monitor samples `y` once per cycle.

## Interface

Parameters: none; all widths are fixed.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wire0`  in  26 signed  operand A.
- `wire1`  in  25 signed  operand B.
- `wire2`  in  15 unsigned  operand C.
- `wire3`  in  6 signed  operand D / shift amount.
- `y`  out  336  packed result word; every bit driven from a flop.

## Operation

Define `IN = {wire3, wire2, wire1, wire0}` (72 bits). `sx()` means sign-extend. All arithmetic is two's complement and truncates to the field width.

`y` fields, LSB first, all updated on each rising `clk`:
- [25:0] sum: `wire0 + sx(wire1)`.
- [51:26] diff: `wire0 - sx(wire1)`.
- [82:52] prod: signed `wire1 * wire3`, full 31-bit product.
- [107:83] mix: `wire1 ^ {wire2, wire3, 4'b0000}`.
- [115:108] flags:
  - b0: `wire0 == 0`.
  - b1: `wire0 < sx(wire1)`, signed compare.
  - b2: `wire1[24]`.
  - b3: `wire3[5]`.
  - b4: XOR-reduce of `wire0`.
  - b5: XOR-reduce of `wire2`.
  - b6: `wire2 == 0`.
  - b7: AND-reduce of `wire3`.
- [163:116] acc: 48-bit accumulator, `acc <= acc + sx(wire0)`, wraps.
- [170:164] pop: number of ones in `IN` (0..72).
- [196:171] shl: `wire0 << wire3[4:0]`, truncated to 26 bits; `wire3[5]` is ignored.
- [268:197] hist: `IN` as sampled one edge before the edge that loaded the other fields. Implemented as two 72-bit registers in series.
- [300:269] misr: `misr <= {misr[30:0], misr[31]^misr[21]^misr[1]^misr[0]} ^ {wire0, wire3}`.
- [335:301] cnt: 35-bit free-running cycle counter, +1 per edge, wraps to 0.

## Timing

- Reset (`rst_n` low): asynchronous, takes effect immediately, no clock needed.
  - All `y` bits become 0, except misr = 32'hFFFFFFFF.
  - Both hist stages clear to 0.
- Reset mid-operation: all accumulated state is lost. After release, the first rising edge loads fresh values; cnt becomes 1.
- Latency:
  - Combinational fields (sum, diff, prod, mix, flags, pop, shl) reflect the inputs present at the previous rising edge: 1 cycle.
  - hist: 2 cycles.
  - acc, misr, cnt: 1 cycle; they fold in the current edge's inputs.
- No handshake; inputs are sampled on every edge and must be stable around the rising edge.
- Boundaries:
  - acc and cnt wrap silently.
  - Shift amounts ≥26 yield 0.
  - Most-negative operands use plain wraparound with no saturation. Example: `wire0 = -2^25`, `wire1 = -1` gives sum = 26'h1FFFFFF.

## Configuration

- `FUZZ_TOP_ACC_EN` defined: the acc field operates as specified.
- Not defined:
  - No accumulator register is generated.
  - `y[163:116]` is tied to constant 0 in and out of reset.
  - All other fields are unchanged.

## Test plan

- Reset: assert `rst_n` low with no clock. Expect `y` = 0 except `y[300:269]` = 32'hFFFFFFFF. Then release and clock once; expect cnt = 1.
- Arithmetic and flags: `wire0=100`, `wire1=-1`, `wire2=0`, `wire3=0`, one edge. Expect:
  - sum = 99, diff = 101, prod = 0.
  - mix = 25'h1FFFFFF, flags = 8'h54, pop = 28, shl = 100.
- Product and shift, step 1: `wire1=-3`, `wire3=5`, `wire0=1`. Expect prod = 31'h7FFFFFF1, shl = 32.
- Product and shift, step 2: `wire3=6'h23`. Expect shl = 8 (only `wire3[4:0]` is used).
- Accumulator: after reset, hold `wire0=-2` for 3 edges. Expect acc = 48'hFFFFFFFFFFFA with `FUZZ_TOP_ACC_EN`, and 0 without it.
- History and wrap:
  - Apply distinct `IN` values V1, V2, V3 on successive edges. After the V3 edge, expect hist = V2.
  - Force cnt to 35'h7FFFFFFFF (or run 2^35 edges in a formal check). The next edge gives cnt = 0.
